ws2812_chain_driver: RTL and testbench
======================================

# ws2812_chain_driver

Parametrised serial LED chain driver that converts NUM_LEDS packed 24-bit RGB colour words into the WS2812 single-wire protocol. It sits between the soft-processor system's colour and start exports and the LED strip pin. It supersedes the fixed 12-channel parallel colour interface with a variable-length chain, a selectable byte order, global brightness scaling and optional continuous refresh. Colours are snapshotted at frame start, so software may rewrite them while a frame is in flight.

## Interface
- NUM_LEDS, 12: LEDs in the chain; must be >= 1.
- T0H_CYC, 20: high-time cycles for a 0 bit.
- T1H_CYC, 40: high-time cycles for a 1 bit.
- BIT_CYC, 63: total cycles per bit; requires 0 < T0H_CYC < T1H_CYC < BIT_CYC.
- RESET_CYC, 2500: low-time latch gap after a frame.
- GRB_ORDER, 1: 1 sends G,R,B; 0 sends R,G,B.

Ports:
- clk_clk  in  1  system clock; single clock domain.
- reset_reset_n  in  1  asynchronous, active-low reset.
- colors  in  24*NUM_LEDS  LED i colour at [24i+23:24i], as {R[7:0],G[7:0],B[7:0]}; LED0 is sent first.
- brightness  in  8  global scale factor; 255 is identity.
- start  in  1  level input; a rising edge requests a frame.
- auto_refresh  in  1  when 1, a new frame starts automatically after each latch gap.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse at the end of the latch gap.
- led_dout  out  1  serial data to the strip; idle low.

## Operation
- States:
  - IDLE.
  - LOAD: one cycle; loads LED0 into the shifter.
  - SEND: per bit, a HIGH phase then a LOW phase.
  - GAP: latch gap.
- start_q holds start registered each cycle. A rising edge is start=1 && start_q=0.
- IDLE to LOAD:
  - Trigger: a rising edge, or an armed pending flag.
  - Action: all colors are copied to the snapshot register, and busy is set to 1.
- LOAD to SEND:
  - Action: the shifter is loaded with the scaled, reordered LED0 word, the bit counter is set to 0, and the LED counter is set to 0.
- Scaling:
  - Applied per byte: out = (c * (brightness + 1)) >> 8, an 8x9-bit product, upper 8 bits kept.
  - brightness=255 passes values unchanged; brightness=0 gives 0 for c<=255.
  - brightness is sampled at each word load.
- Bit order: MSB first within each byte. Byte order is G,R,B when GRB_ORDER=1 and R,G,B when GRB_ORDER=0.
- Each bit period:
  - led_dout is 1 for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then 0 for the rest of BIT_CYC.
  - The period is exactly BIT_CYC cycles.
- The next LED word is prepared during the final bit, so there is no inter-LED gap. The stream is contiguous for NUM_LEDS*24 bits.
- After the last bit, GAP holds led_dout=0 for RESET_CYC cycles.
- On GAP exit:
  - frame_done pulses for one cycle.
  - If pending=1 or auto_refresh=1, the state goes to LOAD with a new snapshot, pending is cleared, and busy stays 1.
  - Otherwise the state goes to IDLE, busy goes to 0, and busy falls on the same edge that frame_done rises.
- A rising edge of start while busy=1 sets pending, one deep. Further edges are absorbed.
- Reset values of all outputs: led_dout=0, busy=0, frame_done=0. State is IDLE, pending=0, and start_q=0.
- Reset asserted mid-frame forces led_dout low immediately (asynchronously). The partial frame is abandoned and is never resumed.

## Timing
- The clock edge that detects a rising edge is edge k.
  - busy=1 from edge k.
  - LOAD occupies k to k+1.
  - led_dout rises at edge k+1.
- The first bit's high phase begins at edge k+1.
- The last bit ends at edge k+1+NUM_LEDS*24*BIT_CYC.
- The GAP then spans RESET_CYC cycles.
- frame_done is high for the single cycle ending at edge k+1+NUM_LEDS*24*BIT_CYC+RESET_CYC, and busy falls at that edge unless a rearm occurs.
- For a back-to-back pending or auto_refresh frame, a one-cycle LOAD is inserted. The frame period is 1 + NUM_LEDS*24*BIT_CYC + RESET_CYC cycles.
- A start edge coincident with the frame_done cycle counts as pending and starts the next frame without returning to IDLE.

## Test plan
Unless a scenario states otherwise, all scenarios use NUM_LEDS=2, T0H_CYC=2, T1H_CYC=4, BIT_CYC=6, RESET_CYC=10, GRB_ORDER=1, brightness=255.
- Single frame: colors LED0=0xFF0000 and LED1=0x00FF01, start pulse -> bit stream 00000000 11111111 00000000 11111111 00000000 00000001. High times are 2 or 4 cycles, the period is always 6, busy lasts 1+288+10 cycles, and frame_done pulses exactly once.
- Byte order: GRB_ORDER=0 with LED0=0x123456 -> first 24 bits are 0x12,0x34,0x56 MSB first. With GRB_ORDER=1 -> 0x34,0x12,0x56.
- Brightness: brightness=127, LED0=0xFF8001 -> scaled bytes R=0x7F, G=0x40, B=0x00. brightness=0 -> all bits use 2-cycle high times.
- Snapshot and pending: change colors and pulse start three times mid-frame -> the current frame is unaltered. Exactly one extra frame follows with the new colours, after a one-cycle LOAD and no IDLE.
- auto_refresh=1 -> frames repeat with a period of 299 cycles. Clearing it mid-frame -> the current frame completes, then busy=0.
- Reset mid-bit during a high phase -> led_dout=0 and busy=0 asynchronously. After release, a new start produces a full, correct frame.

Source files
------------

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver
//
// Serialises NUM_LEDS packed 24-bit {R,G,B} colour words onto a single
// WS2812 data pin. Colours are snapshotted when a frame is accepted, scaled
// by a global brightness factor as each word is loaded, reordered to G,R,B or
// R,G,B, and shifted out MSB first with no gap between LEDs. Each frame ends
// with a RESET_CYC low latch gap. A start edge during a frame is remembered
// (one deep), and auto_refresh chains frames back to back.
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   colors         in   LED i colour at [24i+23:24i]; LED0 is sent first
//   brightness     in   global scale factor, 255 = unchanged
//   start          in   level input; a rising edge requests a frame
//   auto_refresh   in   restart automatically after every latch gap
//   busy           out  frame accepted and not yet finished
//   frame_done     out  one-cycle pulse in the last latch-gap cycle
//   led_dout       out  serial data to the strip, idle low
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a start edge or a pending request
// LOAD  | one cycle: first LED word of the snapshot into the shifter
// SEND  | bit periods: high phase (T0H/T1H) then low phase to BIT_CYC
// GAP   | led_dout low for RESET_CYC cycles, frame_done in last cycle

module ws2812_chain_driver #(
  parameter int NUM_LEDS  = 12,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int RESET_CYC = 2500,
  parameter int GRB_ORDER = 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [24*NUM_LEDS-1:0]  colors,
  input  logic [7:0]              brightness,
  input  logic                    start,
  input  logic                    auto_refresh,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    led_dout
);

  localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(RESET_CYC - 1);
  // The shared down-counter reaches these values exactly T0H/T1H cycles
  // after a bit starts; that is where the high phase ends.
  localparam logic [CNT_W-1:0] T0_DROP  = CNT_W'(BIT_CYC - T0H_CYC);
  localparam logic [CNT_W-1:0] T1_DROP  = CNT_W'(BIT_CYC - T1H_CYC);
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t                 state, state_nxt;
  logic [24*NUM_LEDS-1:0] snap, snap_nxt;
  logic [23:0]            shifter, shifter_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [4:0]             bit_cnt, bit_cnt_nxt;
  logic [LED_W-1:0]       led_cnt, led_cnt_nxt;
  logic                   pending, pending_nxt;
  logic                   start_q;
  logic                   dout_nxt;
  logic                   rise;
  logic [LED_W-1:0]       sel_idx;
  logic [23:0]            raw_word;
  logic [CNT_W-1:0]       drop_at;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [8:0]  b1;
    logic [15:0] prod;
    b1   = {1'b0, b} + 9'd1;
    prod = 16'(c) * 16'(b1);
    return 8'(prod >> 8);
  endfunction

  function automatic logic [23:0] fmt_word(input logic [23:0] rgb, input logic [7:0] b);
    logic [7:0] r, g, bl;
    r  = scale(rgb[23:16], b);
    g  = scale(rgb[15:8], b);
    bl = scale(rgb[7:0], b);
    return (GRB_ORDER != 0) ? {g, r, bl} : {r, g, bl};
  endfunction

  assign rise = start & ~start_q;

  // Word feeding the shifter: LED0 while in LOAD, otherwise the LED after
  // the one currently being sent.
  always_comb begin
    sel_idx = '0;
    if (state == S_SEND && led_cnt != LAST_LED) sel_idx = led_cnt + 1'b1;
    raw_word = snap[23:0];
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (sel_idx == LED_W'(i)) raw_word = snap[24*i +: 24];
    end
  end

  always_comb begin
    state_nxt   = state;
    snap_nxt    = snap;
    shifter_nxt = shifter;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    led_cnt_nxt = led_cnt;
    pending_nxt = pending;
    dout_nxt    = led_dout;
    busy        = (state != S_IDLE);
    frame_done  = (state == S_GAP) && (cnt == '0);
    drop_at     = shifter[23] ? T1_DROP : T0_DROP;

    case (state)
      S_IDLE: begin
        if (rise || pending) begin
          state_nxt   = S_LOAD;
          snap_nxt    = colors;
          pending_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        if (rise) pending_nxt = 1'b1;
        shifter_nxt = fmt_word(raw_word, brightness);
        cnt_nxt     = BIT_LOAD;
        bit_cnt_nxt = '0;
        led_cnt_nxt = '0;
        dout_nxt    = 1'b1;
        state_nxt   = S_SEND;
      end
      S_SEND: begin
        if (rise) pending_nxt = 1'b1;
        if (cnt == '0) begin
          if (bit_cnt == 5'd23) begin
            if (led_cnt == LAST_LED) begin
              state_nxt = S_GAP;
              cnt_nxt   = GAP_LOAD;
              dout_nxt  = 1'b0;
            end else begin
              led_cnt_nxt = led_cnt + 1'b1;
              bit_cnt_nxt = '0;
              shifter_nxt = fmt_word(raw_word, brightness);
              cnt_nxt     = BIT_LOAD;
              dout_nxt    = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
            shifter_nxt = {shifter[22:0], 1'b0};
            cnt_nxt     = BIT_LOAD;
            dout_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == drop_at) dout_nxt = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          // A start edge landing in the frame_done cycle rearms directly.
          if (pending || rise || auto_refresh) begin
            state_nxt   = S_LOAD;
            snap_nxt    = colors;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
          if (rise) pending_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      snap     <= '0;
      shifter  <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      led_cnt  <= '0;
      pending  <= 1'b0;
      start_q  <= 1'b0;
      led_dout <= 1'b0;
    end else begin
      snap     <= snap_nxt;
      shifter  <= shifter_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      led_cnt  <= led_cnt_nxt;
      pending  <= pending_nxt;
      start_q  <= start;
      led_dout <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Directed bench for ws2812_chain_driver with a two-LED chain and short
// timings (T0H=2, T1H=4, BIT=6, RESET=10). Two instances run side by side:
// dut uses G,R,B order, dut_rgb uses R,G,B order. A background recorder
// samples the outputs on every falling edge; each scenario restarts the
// recording, drives stimulus, then decodes the trace against hand-computed
// bit streams.

module tb_ws2812_chain_driver;

  localparam int TR_LEN = 1200;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [47:0] colors = '0;
  logic [7:0]  brightness = 8'd255;
  logic        start = 1'b0;
  logic        auto_refresh = 1'b0;
  logic        busy, frame_done, led_dout;
  logic        busy_r, frame_done_r, led_dout_r;

  int total = 0;
  int bad = 0;

  logic dout_tr [TR_LEN];
  logic busy_tr [TR_LEN];
  logic fd_tr   [TR_LEN];
  logic rgb_tr  [TR_LEN];
  int   rec_gen  = 0;
  int   seen_gen = 0;
  int   rec_n    = 0;

  ws2812_chain_driver #(
    .NUM_LEDS(2), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RESET_CYC(10), .GRB_ORDER(1)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .colors(colors),
    .brightness(brightness), .start(start), .auto_refresh(auto_refresh),
    .busy(busy), .frame_done(frame_done), .led_dout(led_dout)
  );

  ws2812_chain_driver #(
    .NUM_LEDS(2), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RESET_CYC(10), .GRB_ORDER(0)
  ) dut_rgb (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .colors(colors),
    .brightness(brightness), .start(start), .auto_refresh(auto_refresh),
    .busy(busy_r), .frame_done(frame_done_r), .led_dout(led_dout_r)
  );

  initial forever #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) begin
    if (rec_gen != seen_gen) begin
      seen_gen = rec_gen;
      rec_n = 0;
    end
    if (rec_n < TR_LEN) begin
      dout_tr[rec_n] = led_dout;
      busy_tr[rec_n] = busy;
      fd_tr[rec_n]   = frame_done;
      rgb_tr[rec_n]  = led_dout_r;
      rec_n++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Restarts the trace and issues a one-cycle start pulse. Trace index 0 is
  // the cycle before acceptance, 1 is LOAD, 2 is the first bit.
  task automatic kick();
    rec_gen++;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Decodes 48 bit periods of six samples each, starting at trace index s.
  // errs counts periods that are not a clean 2- or 4-sample high pulse
  // followed by low samples.
  function automatic void decode(input bit sel, input int s,
                                 output logic [47:0] bits, output int errs);
    int   h;
    logic v;
    bits = '0;
    errs = 0;
    for (int b = 0; b < 48; b++) begin
      h = 0;
      for (int j = 0; j < 6; j++) begin
        v = sel ? rgb_tr[s + b*6 + j] : dout_tr[s + b*6 + j];
        if (v === 1'b1) begin
          if (h != j) errs++;
          h++;
        end else if (v !== 1'b0) begin
          errs++;
        end
      end
      if (h == 4) bits[47-b] = 1'b1;
      else if (h != 2) errs++;
    end
  endfunction

  function automatic int count_tr(input int which, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (which)
        0: c += int'(dout_tr[i] === 1'b1);
        1: c += int'(busy_tr[i] === 1'b1);
        default: c += int'(fd_tr[i] === 1'b1);
      endcase
    end
    return c;
  endfunction

  task automatic test_reset();
    reset_reset_n = 1'b0;
    step(2);
    total++;
    if ({led_dout, busy, frame_done, led_dout_r} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000", {led_dout, busy, frame_done, led_dout_r});
    end
    reset_reset_n = 1'b1;
    step(5);
    total++;
    if ({led_dout, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=000", {led_dout, busy, frame_done});
    end
  endtask

  task automatic test_single_frame();
    logic [47:0] bits;
    int          errs, n;
    colors = {24'h00FF01, 24'hFF0000};
    kick();
    step(310);
    decode(0, 2, bits, errs);
    total++;
    if (bits !== 48'h00FF00_FF0001) begin
      bad++; $display("FAIL single_bits got=%h want=00ff00ff0001", bits);
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL single_shape got=%0d want=0", errs);
    end
    total++;
    if ({busy_tr[0], busy_tr[1], dout_tr[1], dout_tr[2]} !== 4'b0101) begin
      bad++;
      $display("FAIL single_start got=%b want=0101", {busy_tr[0], busy_tr[1], dout_tr[1], dout_tr[2]});
    end
    n = count_tr(1, 0, 309);
    total++;
    if (n !== 299) begin
      bad++; $display("FAIL single_busy_len got=%0d want=299", n);
    end
    n = count_tr(2, 0, 309);
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL single_fd_count got=%0d want=1", n);
    end
    total++;
    if ({fd_tr[299], busy_tr[299], busy_tr[300]} !== 3'b110) begin
      bad++;
      $display("FAIL single_fd_edge got=%b want=110", {fd_tr[299], busy_tr[299], busy_tr[300]});
    end
    n = count_tr(0, 288, 309);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL single_gap_low got=%0d want=0", n);
    end
  endtask

  task automatic test_byte_order();
    logic [47:0] bits_g, bits_r;
    int          errs_g, errs_r;
    colors = {24'h000000, 24'h123456};
    kick();
    step(310);
    decode(0, 2, bits_g, errs_g);
    decode(1, 2, bits_r, errs_r);
    total++;
    if (bits_r !== 48'h123456_000000) begin
      bad++; $display("FAIL order_rgb got=%h want=123456000000", bits_r);
    end
    total++;
    if (bits_g !== 48'h341256_000000) begin
      bad++; $display("FAIL order_grb got=%h want=341256000000", bits_g);
    end
    total++;
    if (errs_g + errs_r !== 0) begin
      bad++; $display("FAIL order_shape got=%0d want=0", errs_g + errs_r);
    end
  endtask

  task automatic test_brightness();
    logic [47:0] bits_g, bits_r;
    int          errs_g, errs_r;
    brightness = 8'd127;
    colors = {24'h0000FF, 24'hFF8001};
    kick();
    step(310);
    decode(0, 2, bits_g, errs_g);
    decode(1, 2, bits_r, errs_r);
    total++;
    if (bits_g !== 48'h407F00_00007F) begin
      bad++; $display("FAIL bright127_grb got=%h want=407f0000007f", bits_g);
    end
    total++;
    if (bits_r !== 48'h7F4000_00007F) begin
      bad++; $display("FAIL bright127_rgb got=%h want=7f400000007f", bits_r);
    end
    brightness = 8'd0;
    colors = {24'hFFFFFF, 24'hFFFFFF};
    kick();
    step(310);
    decode(0, 2, bits_g, errs_g);
    total++;
    if (bits_g !== 48'h0 || errs_g !== 0) begin
      bad++; $display("FAIL bright0 got=%h errs=%0d want=000000000000 errs=0", bits_g, errs_g);
    end
    brightness = 8'd255;
  endtask

  task automatic test_snapshot_pending();
    logic [47:0] bits;
    int          errs, n;
    colors = {24'h00FF01, 24'hFF0000};
    kick();
    step(48);
    colors = {24'hAA5500, 24'h0000FF};
    for (int p = 0; p < 3; p++) begin
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
    end
    step(600);
    decode(0, 2, bits, errs);
    total++;
    if (bits !== 48'h00FF00_FF0001 || errs !== 0) begin
      bad++; $display("FAIL snap_frame1 got=%h errs=%0d want=00ff00ff0001 errs=0", bits, errs);
    end
    decode(0, 301, bits, errs);
    total++;
    if (bits !== 48'h0000FF_55AA00 || errs !== 0) begin
      bad++; $display("FAIL snap_frame2 got=%h errs=%0d want=0000ff55aa00 errs=0", bits, errs);
    end
    total++;
    if ({fd_tr[299], busy_tr[300], dout_tr[300], fd_tr[598], busy_tr[599]} !== 5'b11010) begin
      bad++;
      $display("FAIL snap_rearm got=%b want=11010",
               {fd_tr[299], busy_tr[300], dout_tr[300], fd_tr[598], busy_tr[599]});
    end
    n = count_tr(2, 0, 650);
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL snap_frame_count got=%0d want=2", n);
    end
    n = count_tr(1, 0, 650);
    total++;
    if (n !== 598) begin
      bad++; $display("FAIL snap_busy_len got=%0d want=598", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] bits;
    int          errs, n;
    colors = {24'h00FF01, 24'hFF0000};
    kick();
    step(298);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(320);
    total++;
    if ({fd_tr[299], busy_tr[300], fd_tr[598], busy_tr[599]} !== 4'b1110) begin
      bad++;
      $display("FAIL b2b_fd_edge got=%b want=1110", {fd_tr[299], busy_tr[300], fd_tr[598], busy_tr[599]});
    end
    decode(0, 301, bits, errs);
    total++;
    if (bits !== 48'h00FF00_FF0001 || errs !== 0) begin
      bad++; $display("FAIL b2b_frame2 got=%h errs=%0d want=00ff00ff0001 errs=0", bits, errs);
    end
    n = count_tr(2, 0, 615);
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL b2b_frame_count got=%0d want=2", n);
    end
  endtask

  task automatic test_auto_refresh();
    logic [47:0] bits;
    int          errs, n;
    colors = {24'hF0F0F0, 24'h0F0F0F};
    auto_refresh = 1'b1;
    kick();
    step(650);
    auto_refresh = 1'b0;
    step(300);
    total++;
    if ({fd_tr[299], busy_tr[300], fd_tr[598], busy_tr[599], fd_tr[897], busy_tr[898]} !== 6'b111110) begin
      bad++;
      $display("FAIL auto_period got=%b want=111110",
               {fd_tr[299], busy_tr[300], fd_tr[598], busy_tr[599], fd_tr[897], busy_tr[898]});
    end
    decode(0, 600, bits, errs);
    total++;
    if (bits !== 48'h0F0F0F_F0F0F0 || errs !== 0) begin
      bad++; $display("FAIL auto_frame3 got=%h errs=%0d want=0f0f0ff0f0f0 errs=0", bits, errs);
    end
    n = count_tr(2, 0, 940);
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL auto_frame_count got=%0d want=3", n);
    end
    n = count_tr(1, 0, 940);
    total++;
    if (n !== 897) begin
      bad++; $display("FAIL auto_busy_len got=%0d want=897", n);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] bits;
    int          errs, n;
    colors = {24'hFFFFFF, 24'hFFFFFF};
    kick();
    step(1);
    total++;
    if ({led_dout, busy} !== 2'b11) begin
      bad++; $display("FAIL midrst_pre got=%b want=11", {led_dout, busy});
    end
    reset_reset_n = 1'b0;
    #1;
    total++;
    if ({led_dout, busy, frame_done, led_dout_r} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_async got=%b want=0000", {led_dout, busy, frame_done, led_dout_r});
    end
    step(3);
    reset_reset_n = 1'b1;
    step(3);
    total++;
    if ({led_dout, busy} !== 2'b00) begin
      bad++; $display("FAIL midrst_no_resume got=%b want=00", {led_dout, busy});
    end
    colors = {24'h00FF01, 24'hFF0000};
    kick();
    step(310);
    decode(0, 2, bits, errs);
    total++;
    if (bits !== 48'h00FF00_FF0001 || errs !== 0) begin
      bad++; $display("FAIL midrst_frame got=%h errs=%0d want=00ff00ff0001 errs=0", bits, errs);
    end
    n = count_tr(1, 0, 309);
    total++;
    if (n !== 299) begin
      bad++; $display("FAIL midrst_busy_len got=%0d want=299", n);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_byte_order();
    test_brightness();
    test_snapshot_pending();
    test_back_to_back();
    test_auto_refresh();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
